// File: rtl/tetris_input_conditioner.sv
// tetris_input_conditioner: synchronise, debounce and edge-detect the eight
// JB controller lines, auto-repeat Left/Right/Down, and queue press events.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-low reset
//   btn_raw    asynchronous active-high buttons
//              [0] Up [1] Right [2] Down [3] Left [4] SL [5] SR [6] Hold [7] Reset
//   ack        one-cycle pulse, consumes the event shown on cmd_code
//   cmd_valid  high while any event is pending
//   cmd_code   highest-priority pending event code, 0 when none
//   btn_level  debounced button levels
module tetris_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int DAS_CYCLES      = 8_000_000,
   parameter int ARR_CYCLES      = 2_500_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] btn_raw,
   input  logic       ack,
   output logic       cmd_valid,
   output logic [3:0] cmd_code,
   output logic [7:0] btn_level
);

   localparam int DB_W =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int RP_MAX =
      (DAS_CYCLES > ARR_CYCLES) ? DAS_CYCLES : ARR_CYCLES;
   localparam int RP_W =
      (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] DAS_LAST = RP_W'(DAS_CYCLES - 1);
   localparam logic [RP_W-1:0] ARR_LAST = RP_W'(ARR_CYCLES - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DELAY  = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   logic [7:0]      sync_a;
   logic [7:0]      sync_b;
   logic [DB_W-1:0] db_cnt [8];
   logic [7:0]      level_q;
   logic [7:0]      rise;

   logic [1:0]      rp_state   [3];
   logic [1:0]      rp_state_n [3];
   logic [RP_W-1:0] rp_cnt     [3];
   logic [RP_W-1:0] rp_cnt_n   [3];
   logic [2:0]      rp_fire;

   logic [7:0]      pending;
   logic [7:0]      pending_n;
   logic [7:0]      set_vec;
   logic [7:0]      sel_mask;
   logic [7:0]      clr_vec;

   // Two-flop synchroniser
   always_ff @(posedge clock) begin
      if (!reset) begin
         sync_a <= '0;
         sync_b <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
      end
   end

   // Debounce: level toggles only after DEBOUNCE_CYCLES
   // consecutive cycles of disagreement with the synchronised input.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 8; i++) begin
            db_cnt[i] <= '0;
         end
         btn_level <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (sync_b[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]    <= '0;
               btn_level[i] <= ~btn_level[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         level_q <= '0;
      end else begin
         level_q <= btn_level;
      end
   end

   assign rise = btn_level & ~level_q;

   // Auto-repeat FSMs for Right/Down/Left (bits 1..3).
   // A released button forces IDLE ahead of any terminal count.
   always_comb begin
      for (int j = 0; j < 3; j++) begin
         rp_state_n[j] = rp_state[j];
         rp_cnt_n[j]   = rp_cnt[j];
         rp_fire[j]    = 1'b0;
         if (!btn_level[j+1]) begin
            rp_state_n[j] = ST_IDLE;
            rp_cnt_n[j]   = '0;
         end else begin
            unique case (rp_state[j])
               ST_IDLE: begin
                  if (rise[j+1]) begin
                     rp_fire[j]    = 1'b1;
                     rp_cnt_n[j]   = '0;
                     rp_state_n[j] = ST_DELAY;
                  end
               end
               ST_DELAY: begin
                  if (rp_cnt[j] == DAS_LAST) begin
                     rp_fire[j]    = 1'b1;
                     rp_cnt_n[j]   = '0;
                     rp_state_n[j] = ST_REPEAT;
                  end else begin
                     rp_cnt_n[j] = rp_cnt[j] + RP_W'(1);
                  end
               end
               ST_REPEAT: begin
                  if (rp_cnt[j] == ARR_LAST) begin
                     rp_fire[j]  = 1'b1;
                     rp_cnt_n[j] = '0;
                  end else begin
                     rp_cnt_n[j] = rp_cnt[j] + RP_W'(1);
                  end
               end
               default: begin
                  rp_state_n[j] = ST_IDLE;
                  rp_cnt_n[j]   = '0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int j = 0; j < 3; j++) begin
            rp_state[j] <= ST_IDLE;
            rp_cnt[j]   <= '0;
         end
      end else begin
         for (int j = 0; j < 3; j++) begin
            rp_state[j] <= rp_state_n[j];
            rp_cnt[j]   <= rp_cnt_n[j];
         end
      end
   end

   assign set_vec = {rise[7:4], rp_fire, rise[0]};

   // Priority encode of the pending set; sel_mask marks
   // the single bit that an ack would consume.
   always_comb begin
      cmd_code = 4'd0;
      sel_mask = 8'h00;
      if (pending[7]) begin
         cmd_code = 4'd10;
         sel_mask = 8'h80;
      end else if (pending[6]) begin
         cmd_code = 4'd9;
         sel_mask = 8'h40;
      end else if (pending[5]) begin
         cmd_code = 4'd8;
         sel_mask = 8'h20;
      end else if (pending[4]) begin
         cmd_code = 4'd7;
         sel_mask = 8'h10;
      end else if (pending[3]) begin
         cmd_code = 4'd4;
         sel_mask = 8'h08;
      end else if (pending[2]) begin
         cmd_code = 4'd3;
         sel_mask = 8'h04;
      end else if (pending[1]) begin
         cmd_code = 4'd2;
         sel_mask = 8'h02;
      end else if (pending[0]) begin
         cmd_code = 4'd1;
         sel_mask = 8'h01;
      end
   end

   assign cmd_valid = |pending;
   assign clr_vec   = (ack && cmd_valid) ? sel_mask : 8'h00;

   // Set wins over a same-cycle clear so a racing event merges.
   assign pending_n = (pending & ~clr_vec) | set_vec;

   always_ff @(posedge clock) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         pending <= pending_n;
      end
   end

endmodule
